// File: rtl/mvm_pkg.sv
// Shared constants, types and operand-initialisation helpers for the mvm_unit engine.
package mvm_pkg;

   localparam int unsigned N    = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned ACCW = 2 * DW + $clog2(N);
   localparam int unsigned IW   = $clog2(N);

   typedef logic signed [DW-1:0]   opnd_t;
   typedef logic signed [ACCW-1:0] acc_t;
   typedef logic [IW-1:0]          idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Fixed operand contents: A[i][j] = i - j, x[j] = j + 1.
   function automatic opnd_t a_elem(input int unsigned row, input int unsigned col);
      return opnd_t'(int'(row) - int'(col));
   endfunction

   function automatic opnd_t x_elem(input int unsigned col);
      return opnd_t'(col + 1);
   endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate with clear and row-result load; optional ReLU clamp via MVM_RELU_EN.
module mvm_mac
   import mvm_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic signed [DW-1:0]   i_a,
   input  logic signed [DW-1:0]   i_x,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic                   i_last,
   output logic signed [ACCW-1:0] o_result
);

   acc_t r_acc;
   acc_t r_result;
   acc_t w_p;
   acc_t w_sum;
   acc_t w_res;

   always_comb begin
      w_p   = acc_t'(i_a) * acc_t'(i_x);
      w_sum = r_acc + w_p;
`ifdef MVM_RELU_EN
      w_res = w_sum[ACCW-1] ? '0 : w_sum;
`else
      w_res = w_sum;
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_result <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         if (i_last) begin
            r_acc    <= '0;
            r_result <= w_res;
         end else begin
            r_acc <= w_sum;
         end
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/mvm_unit.sv
// Matrix-vector multiply engine y = A*x, one MAC per cycle; ReLU output option via MVM_RELU_EN.
module mvm_unit
   import mvm_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   output logic                   DONE,
   output logic signed [DW-1:0]   IDATA_O1,
   output logic signed [DW-1:0]   IDATA_O2,
   output logic signed [ACCW-1:0] ODATA_O,
   output logic                   ODATA_VALID
);

   state_t r_state;
   idx_t   r_i;
   idx_t   r_j;
   logic   r_done;
   logic   r_valid;
   opnd_t  r_o1;
   opnd_t  r_o2;
   opnd_t  r_a [N][N];
   opnd_t  r_x [N];

   logic   w_clr;
   logic   w_en;
   logic   w_last_col;
   logic   w_last_row;
   opnd_t  w_a;
   opnd_t  w_x;

   always_comb begin
      w_last_col = (r_j == idx_t'(N - 1));
      w_last_row = (r_i == idx_t'(N - 1));
      w_clr      = (r_state == IDLE) && START;
      w_en       = (r_state == RUN);
      w_a        = r_a[r_i][r_j];
      w_x        = r_x[r_j];
   end

   // Operand store is only written on reset; computation reads it unchanged.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned k = 0; k < N; k++) begin
            r_x[k] <= x_elem(k);
            for (int unsigned m = 0; m < N; m++) begin
               r_a[k][m] <= a_elem(k, m);
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_o1    <= '0;
         r_o2    <= '0;
      end else begin
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_state <= RUN;
                  r_i     <= '0;
                  r_j     <= '0;
               end
            end
            RUN: begin
               r_o1 <= w_a;
               r_o2 <= w_x;
               if (w_last_col) begin
                  r_valid <= 1'b1;
                  r_j     <= '0;
                  if (w_last_row) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                     r_i     <= '0;
                  end else begin
                     r_i <= r_i + 1'b1;
                  end
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mvm_mac u_mac (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_a      (w_a),
      .i_x      (w_x),
      .i_clr    (w_clr),
      .i_en     (w_en),
      .i_last   (w_last_col),
      .o_result (ODATA_O)
   );

   assign DONE        = r_done;
   assign ODATA_VALID = r_valid;
   assign IDATA_O1    = r_o1;
   assign IDATA_O2    = r_o2;

endmodule

// File: tb/tb_mvm_unit.sv
// Directed self-checking bench for mvm_unit (N=4, DW=8); expectations follow MVM_RELU_EN.
module tb_mvm_unit;

   localparam int unsigned DW   = 8;
   localparam int unsigned ACCW = 18;

   logic                   CLK;
   logic                   RST;
   logic                   START;
   logic                   DONE;
   logic signed [DW-1:0]   IDATA_O1;
   logic signed [DW-1:0]   IDATA_O2;
   logic signed [ACCW-1:0] ODATA_O;
   logic                   ODATA_VALID;

   int checks = 0;
   int errors = 0;
   int row_exp [4];

   mvm_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .DONE        (DONE),
      .IDATA_O1    (IDATA_O1),
      .IDATA_O2    (IDATA_O2),
      .ODATA_O     (ODATA_O),
      .ODATA_VALID (ODATA_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"},  int'(DONE),        0);
      chk({tag, "_valid"}, int'(ODATA_VALID), 0);
      chk({tag, "_o1"},    int'(IDATA_O1),    0);
      chk({tag, "_o2"},    int'(IDATA_O2),    0);
      chk({tag, "_odata"}, int'(ODATA_O),     0);
   endtask

   // Edge 0 (START sampled) is done by the caller; this checks edges 1..16.
   task automatic watch_run(input string tag, input bit busy, input bit chain);
      int nvalid;
      nvalid = 0;
      for (int e = 1; e <= 16; e++) begin
         if (busy && (e == 3 || e == 9)) START = 1'b1;
         tick();
         START = 1'b0;
         chk($sformatf("%s_valid_e%0d", tag, e), int'(ODATA_VALID), (e % 4 == 0) ? 1 : 0);
         chk($sformatf("%s_done_e%0d", tag, e),  int'(DONE),        (e == 16) ? 1 : 0);
         if (e % 4 == 0) begin
            chk($sformatf("%s_row%0d", tag, nvalid), int'(ODATA_O), row_exp[nvalid]);
            nvalid++;
         end
         if (e == 1) begin
            chk({tag, "_o1_e1"}, int'(IDATA_O1), 0);
            chk({tag, "_o2_e1"}, int'(IDATA_O2), 1);
         end
         if (e == 6) begin
            chk({tag, "_o1_e6"}, int'(IDATA_O1), 0);
            chk({tag, "_o2_e6"}, int'(IDATA_O2), 2);
         end
      end
      if (chain) START = 1'b1;
   endtask

   initial begin
`ifdef MVM_RELU_EN
      row_exp = '{0, 0, 0, 10};
`else
      row_exp = '{-20, -10, 0, 10};
`endif
      START = 1'b0;
      RST   = 1'b1;
      #12;
      chk_zero("rst_held");
      RST = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      chk_zero("rst_idle20");

      // Basic run
      START = 1'b1;
      tick();
      START = 1'b0;
      watch_run("basic", 1'b0, 1'b0);
      tick();
      chk("basic_done_after", int'(DONE), 0);
      chk("basic_hold", int'(ODATA_O), row_exp[3]);

      // Async reset mid-cycle, observed before the next edge
      #3 RST = 1'b1;
      #1 chk_zero("rst_async");
      #2 RST = 1'b0;

      // START pulses while running are ignored
      tick();
      START = 1'b1;
      tick();
      START = 1'b0;
      watch_run("busy", 1'b1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("busy_nodone_%0d", c), int'(DONE), 0);
      end

      // Back-to-back: START held in the DONE cycle
      START = 1'b1;
      tick();
      START = 1'b0;
      watch_run("b2b_first", 1'b0, 1'b1);
      tick();
      START = 1'b0;
      watch_run("b2b_second", 1'b0, 1'b0);

      // Reset mid-run after edge 6
      tick();
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int e = 1; e <= 6; e++) tick();
      #2 RST = 1'b1;
      #1 chk_zero("rst_midrun");
      #2 RST = 1'b0;
      for (int c = 0; c < 16; c++) begin
         tick();
         chk($sformatf("abort_nodone_%0d", c), int'(DONE), 0);
         chk($sformatf("abort_novalid_%0d", c), int'(ODATA_VALID), 0);
      end
      chk("abort_odata", int'(ODATA_O), 0);

      START = 1'b1;
      tick();
      START = 1'b0;
      watch_run("fresh", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mvm_unit.md
Name: mvm_unit

Overview:
- Single-clock matrix-vector multiply engine. Computes y = A·x for a fixed N×N signed matrix A and N-element signed vector x, both held in internal registers.
- A START pulse runs the computation at one multiply-accumulate per cycle.
- Operands are streamed out for observation, and each row result is presented on ODATA_O.
- Top-level compute block; clocking is local only (no separate network clock).

Parameters:
- N, 4, matrix dimension (rows = columns = vector length); must be ≥2.
- DW, 8, signed operand width.
- ACCW, 2*DW+$clog2(N), signed accumulator/result width (18 at defaults).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle start request; sampled only in IDLE.
- DONE  out  1  one-cycle pulse when the final row result is presented.
- IDATA_O1  out  DW  matrix element A[i][j] consumed by the most recent MAC.
- IDATA_O2  out  DW  vector element x[j] consumed by the most recent MAC.
- ODATA_O  out  ACCW  latest completed row result y[i]; holds between updates.
- ODATA_VALID  out  1  one-cycle pulse when ODATA_O is updated.

Behaviour:
- Operand contents are fixed, reloaded on reset and unchanged by computation:
  - A[i][j] = i − j, signed DW.
  - x[j] = j + 1, signed DW.
- Reset (async assert): state=IDLE; i=j=0; acc=0; DONE=0; ODATA_VALID=0; IDATA_O1=0; IDATA_O2=0; ODATA_O=0.
- Reset mid-run aborts immediately with no partial DONE.
- IDLE:
  - START=1 at an edge → RUN with i=0, j=0, acc=0.
  - Outputs other than the pulses hold their values.
- RUN, each edge:
  - Compute p = A[i][j]*x[j] (signed, sign-extended to ACCW).
  - IDATA_O1 ← A[i][j]; IDATA_O2 ← x[j].
  - If j < N−1: acc ← acc+p; j ← j+1.
  - If j = N−1: ODATA_O ← acc+p; ODATA_VALID ← 1; acc ← 0; j ← 0; i ← i+1.
  - If additionally i = N−1: DONE ← 1; state ← IDLE; i ← 0.
- Pulses: DONE and ODATA_VALID are 1 for exactly one cycle, otherwise 0.
- Latency, with the START-sampling edge as edge 0:
  - Row r result appears after edge N·(r+1).
  - DONE appears after edge N², coincident with the last ODATA_VALID.
- START while RUN is ignored (no restart, no queueing).
- START asserted in the same cycle DONE is high is accepted (back-to-back runs, zero idle gap).
- Arithmetic: no overflow by construction (ACCW sized for N full-scale products); two's-complement wrap otherwise.

Optional Feature:
- Macro MVM_RELU_EN.
- Defined: value written to ODATA_O is max(acc+p, 0), i.e. negative row results are clamped to 0. ODATA_VALID and DONE timing are unchanged.
- Undefined: ODATA_O carries the raw signed sum.

Decomposition:
- Package mvm_pkg holds:
  - N, DW, ACCW constants.
  - Signed operand/accumulator typedefs.
  - State enum {IDLE, RUN}.
  - Function computing initial A/x contents.
- One sub-module: mvm_mac, a combinational signed multiply plus registered accumulator with clear and load-result controls.
- FSM and index counters stay in mvm_unit.

Test Plan:
- Reset: assert RST asynchronously mid-cycle → all outputs 0 immediately; after release, outputs stay 0 with START low for 20 cycles.
- Basic run (N=4): one START pulse → 4 ODATA_VALID pulses after edges 4, 8, 12, 16 with ODATA_O = −20, −10, 0, 10. DONE coincides with the 10. IDATA_O1/IDATA_O2 after edge 1 = 0/1; after edge 6 = 0/2.
- Busy START: pulse START again at edges 3 and 9 → ignored; results and timing identical to the basic run; exactly one DONE.
- Back-to-back: START high in the DONE cycle → second run starts; its first ODATA_VALID comes 4 cycles later with −20.
- Reset mid-run: assert RST after edge 6 → no DONE; ODATA_O=0. A fresh START then yields −20, −10, 0, 10.
- MVM_RELU_EN defined: basic run → ODATA_O = 0, 0, 0, 10 with identical pulse timing.
